// File: rtl/coeff_load_sequencer_if.sv
// ----------------------------------------------------------------------------
// coeff_load_sequencer_if
// Valid/ready coefficient stream into the coefficient load sequencer.
//   coef_in     : coefficient word (DATA_WIDTH bits), source -> sequencer
//   coef_valid  : coef_in holds a valid word,         source -> sequencer
//   coef_ready  : sequencer accepts coef_in this cycle, sequencer -> source
// Modports: master = word source, slave = sequencer.
// ----------------------------------------------------------------------------
interface coeff_load_sequencer_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] coef_in;
   logic                  coef_valid;
   logic                  coef_ready;

   modport master (
      output coef_in,
      output coef_valid,
      input  coef_ready
   );

   modport slave (
      input  coef_in,
      input  coef_valid,
      output coef_ready
   );
endinterface

// File: rtl/coeff_load_sequencer.sv
// ----------------------------------------------------------------------------
// coeff_load_sequencer
// Upstream control for the 2-to-4 tap-select decoder of the FIR datapath.
// Takes coefficient words one at a time over a valid/ready stream, stores
// them in a coefficient bank, and for each accepted word emits the tap index
// on {sel_hi,sel_lo} with a one-cycle dec_en strobe. coefs_loaded flags that
// the whole set is present.
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   load_start   : one-cycle request to begin/restart a load (ignored mid-load)
//   cif          : coefficient stream (slave side: coef_in/coef_valid in,
//                  coef_ready out)
//   sel_hi/sel_lo: decoder select MSB/LSB (tap index of the last word)
//   dec_en       : decoder enable strobe, one cycle per accepted word
//   coef_bus     : stored taps, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   coefs_loaded : full coefficient set valid
//   busy         : load in progress
// All outputs are registered.
// ----------------------------------------------------------------------------
module coeff_load_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_TAPS   = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load_start,
   coeff_load_sequencer_if.slave            cif,
   output logic                             sel_hi,
   output logic                             sel_lo,
   output logic                             dec_en,
   output logic [NUM_TAPS*DATA_WIDTH-1:0]   coef_bus,
   output logic                             coefs_loaded,
   output logic                             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Tap index is 2 bits wide because the decoder select is 2 bits.
   localparam logic [1:0] LAST_IDX = 2'(NUM_TAPS - 1);

   state_t     state;
   logic [1:0] idx;
   logic       take;

   // coef_ready is registered and high exactly while in LOAD.
   assign take = (state == LOAD) && cif.coef_valid && cif.coef_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= 2'd0;
         cif.coef_ready <= 1'b0;
         sel_hi         <= 1'b0;
         sel_lo         <= 1'b0;
         dec_en         <= 1'b0;
         coef_bus       <= '0;
         coefs_loaded   <= 1'b0;
         busy           <= 1'b0;
      end else begin
         // Strobe defaults low; it is re-armed only on an accepted word.
         dec_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (load_start) begin
                  state          <= LOAD;
                  idx            <= 2'd0;
                  coefs_loaded   <= 1'b0;
                  busy           <= 1'b1;
                  cif.coef_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (take) begin
                  for (int k = 0; k < NUM_TAPS; k++) begin
                     if (idx == 2'(k)) begin
                        coef_bus[k*DATA_WIDTH +: DATA_WIDTH] <= cif.coef_in;
                     end
                  end
                  {sel_hi, sel_lo} <= idx;
                  dec_en           <= 1'b1;
                  idx              <= idx + 2'd1;
                  // Last tap: leave LOAD on the same edge so coefs_loaded
                  // rises together with the final strobe.
                  if (idx == LAST_IDX) begin
                     state          <= DONE;
                     cif.coef_ready <= 1'b0;
                     busy           <= 1'b0;
                     coefs_loaded   <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coeff_load_sequencer.sv
// ----------------------------------------------------------------------------
// tb_coeff_load_sequencer
// Scoreboard bench: the stimulus process updates a tap-array reference model
// and queues one expected strobe record per accepted word; a monitor on the
// falling edge pops and compares whenever the strobe is due.
// ----------------------------------------------------------------------------
module tb_coeff_load_sequencer;
   localparam int DW = 8;
   localparam int NT = 3;

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_DONE = 2;

   typedef struct {
      int               cyc;
      logic [1:0]       sel;
      logic [NT*DW-1:0] bus;
      logic             loaded;
   } sb_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             load_start = 1'b0;
   logic             sel_hi, sel_lo, dec_en, coefs_loaded, busy;
   logic [NT*DW-1:0] coef_bus;

   coeff_load_sequencer_if #(.DATA_WIDTH(DW)) cif();

   coeff_load_sequencer #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .cif          (cif),
      .sel_hi       (sel_hi),
      .sel_lo       (sel_lo),
      .dec_en       (dec_en),
      .coef_bus     (coef_bus),
      .coefs_loaded (coefs_loaded),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain tap array plus load progress.
   logic [DW-1:0] m_tap [NT];
   int            m_state;
   int            m_cnt;
   int            m_sel;
   sb_t           sb_q [$];
   sb_t           mon_e;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [NT*DW-1:0] model_bus();
      logic [NT*DW-1:0] b;
      for (int k = 0; k < NT; k++) b[k*DW +: DW] = m_tap[k];
      return b;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NT; k++) m_tap[k] = '0;
      m_state = M_IDLE;
      m_cnt   = 0;
      m_sel   = 0;
      sb_q.delete();
   endtask

   // Effect of the upcoming rising edge on the model.
   task automatic model_edge(input logic ls, input logic v, input logic [DW-1:0] d);
      sb_t e;
      if (m_state != M_LOAD) begin
         if (ls) begin
            m_state = M_LOAD;
            m_cnt   = 0;
         end
      end else if (v) begin
         m_tap[m_cnt] = d;
         m_sel        = m_cnt;
         e.cyc        = cyc + 1;
         e.sel        = 2'(m_cnt);
         e.bus        = model_bus();
         e.loaded     = (m_cnt == NT - 1);
         sb_q.push_back(e);
         m_cnt++;
         if (m_cnt == NT) m_state = M_DONE;
      end
   endtask

   task automatic check_ctrl();
      chk("coef_ready",   64'(cif.coef_ready), 64'(m_state == M_LOAD));
      chk("busy",         64'(busy),           64'(m_state == M_LOAD));
      chk("coefs_loaded", 64'(coefs_loaded),   64'(m_state == M_DONE));
      chk("coef_bus",     64'(coef_bus),       64'(model_bus()));
      chk("sel_hold",     64'({sel_hi, sel_lo}), 64'(m_sel));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"},  64'(cif.coef_ready), 64'(0));
      chk({tag, "_sel"},    64'({sel_hi, sel_lo}), 64'(0));
      chk({tag, "_dec_en"}, 64'(dec_en), 64'(0));
      chk({tag, "_bus"},    64'(coef_bus), 64'(0));
      chk({tag, "_loaded"}, 64'(coefs_loaded), 64'(0));
      chk({tag, "_busy"},   64'(busy), 64'(0));
   endtask

   // Called on a falling edge; applies inputs for the next rising edge and
   // returns on the following falling edge.
   task automatic step(input logic ls, input logic v, input logic [DW-1:0] d);
      load_start     = ls;
      cif.coef_valid = v;
      cif.coef_in    = d;
      model_edge(ls, v, d);
      @(negedge clk);
      load_start     = 1'b0;
      cif.coef_valid = 1'b0;
      check_ctrl();
   endtask

   task automatic load3(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input logic [DW-1:0] w2, input int gap);
      logic [DW-1:0] w [3];
      w[0] = w0; w[1] = w1; w[2] = w2;
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, w[i]);
         if (i < 2) repeat (gap) step(1'b0, 1'b0, 8'h5A);
      end
   endtask

   // Monitor: compare each due strobe against its queued record.
   always @(negedge clk) begin
      if (!rst) begin
         if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            mon_e = sb_q.pop_front();
            chk("strobe_en",     64'(dec_en), 64'(1));
            chk("strobe_sel",    64'({sel_hi, sel_lo}), 64'(mon_e.sel));
            chk("strobe_bus",    64'(coef_bus), 64'(mon_e.bus));
            chk("strobe_loaded", 64'(coefs_loaded), 64'(mon_e.loaded));
         end else begin
            chk("no_strobe", 64'(dec_en), 64'(0));
         end
      end
   end

   initial begin
      cif.coef_in    = '0;
      cif.coef_valid = 1'b0;
      model_reset();
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Words presented while idle are ignored.
      step(1'b0, 1'b1, 8'hAA);
      step(1'b0, 1'b1, 8'hAA);

      // Back-to-back load.
      load3(8'h11, 8'h22, 8'h33, 0);
      chk("t1_bus", 64'(coef_bus), 64'(24'h332211));
      chk("t1_loaded", 64'(coefs_loaded), 64'(1));

      // Load with two idle cycles between words.
      load3(8'h11, 8'h22, 8'h33, 2);
      chk("t2_bus", 64'(coef_bus), 64'(24'h332211));

      // Words presented while done are ignored.
      step(1'b0, 1'b1, 8'hAA);
      step(1'b0, 1'b1, 8'hAA);

      // Reload over an existing set.
      load3(8'h01, 8'h02, 8'h03, 0);
      load3(8'h7F, 8'h80, 8'hFF, 1);
      chk("t4_bus", 64'(coef_bus), 64'(24'hFF807F));

      // load_start during a load is ignored.
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 8'h44);
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 8'h55);
      step(1'b0, 1'b1, 8'h66);
      chk("t6_bus", 64'(coef_bus), 64'(24'h665544));

      // Asynchronous reset mid-load, checked before the next rising edge.
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 8'hA1);
      step(1'b0, 1'b1, 8'hB2);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      load3(8'hC1, 8'hC2, 8'hC3, 1);
      chk("t5_bus", 64'(coef_bus), 64'(24'hC3C2C1));

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("sb_drain", 64'(sb_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
